// File: rtl/obi_arb_pkg.sv
// Shared widths, the request bundle type and the round-robin pick helper
// for the OBI host-port arbiter.
package obi_arb_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  // rr_pick works on a fixed maximum width; callers zero-extend their
  // request vector and pass the real requester count.
  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  // First asserted request scanning upward from ptr, wrapping at num_req.
  // Returns ptr when nothing is requesting (the result is unused then).
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [RR_IDX_W-1:0]   ptr,
    input int                    num_req
  );
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int                  idx;
    int                  base;
    pick  = ptr;
    found = 1'b0;
    base  = int'(ptr);
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      if (!found && (i < num_req)) begin
        idx = (base + i) % num_req;
        if (req[idx[RR_IDX_W-1:0]]) begin
          pick  = idx[RR_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Small synchronous FIFO holding the master index of each outstanding host
// transaction. The head is read combinationally so responses route in the
// same cycle they arrive.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_id_i;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI host port among NUM_REQ masters.
// Requests pass through combinationally, a stalled grant is locked until
// the host accepts it, and an ID FIFO routes in-order responses back.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  input  logic [NUM_REQ-1:0][OBI_ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][OBI_BE_W-1:0]     be_i,
  input  logic [NUM_REQ-1:0][OBI_DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [NUM_REQ-1:0][OBI_DATA_W-1:0]   rdata_o,
  output logic                                 host_req_o,
  output logic [OBI_ADDR_W-1:0]                host_addr_o,
  output logic                                 host_we_o,
  output logic [OBI_BE_W-1:0]                  host_be_o,
  output logic [OBI_DATA_W-1:0]                host_wdata_o,
  input  logic                                 host_gnt_i,
  input  logic                                 host_rvalid_i,
  input  logic [OBI_DATA_W-1:0]                host_rdata_i,
  output logic                                 err_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] r_ptr;
  logic            r_lock_vld;
  logic [ID_W-1:0] r_lock_id;
  logic            r_err;

  obi_req_t        w_req [NUM_REQ];
  obi_req_t        w_sel_req;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_sel;
  logic [ID_W-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_handshake;
  logic            w_pop;

  // Per-lane request bundling and response data fan-out.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_req[gi] = '{addr: addr_i[gi], we: we_i[gi], be: be_i[gi], wdata: wdata_i[gi]};
    assign rdata_o[gi] = host_rdata_i;
  end

  assign w_pick      = ID_W'(rr_pick(RR_MAX_REQ'(req_i), RR_IDX_W'(r_ptr), NUM_REQ));
  assign w_sel       = r_lock_vld ? r_lock_id : w_pick;
  assign w_sel_req   = w_req[w_sel];
  assign host_req_o  = (|req_i) && !w_full;
  assign w_handshake = host_req_o && host_gnt_i;
  assign w_pop       = host_rvalid_i && !w_empty;
  assign err_o       = r_err;

  // Host fields are zeroed when idle so a quiet arbiter drives all-zero outputs.
  assign host_addr_o  = host_req_o ? w_sel_req.addr  : '0;
  assign host_we_o    = host_req_o ? w_sel_req.we    : 1'b0;
  assign host_be_o    = host_req_o ? w_sel_req.be    : '0;
  assign host_wdata_o = host_req_o ? w_sel_req.wdata : '0;

  // Grant and response-valid steering to a single master lane.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (w_handshake) gnt_o[w_sel] = 1'b1;
    if (w_pop)       rvalid_o[w_head] = 1'b1;
  end

  // Priority pointer advances past the master just served.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_handshake) begin
      r_ptr <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : (w_sel + ID_W'(1));
    end
  end

  // Lock holds a stalled winner on the host channel until it is granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
    end else if (w_handshake) begin
      r_lock_vld <= 1'b0;
    end else if (host_req_o) begin
      r_lock_vld <= 1'b1;
      r_lock_id  <= w_sel;
    end
  end

  // Sticky error for a host response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (host_rvalid_i && w_empty) begin
      r_err <= 1'b1;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_handshake),
    .push_id_i (w_sel),
    .pop_i     (w_pop),
    .head_o    (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

endmodule
